// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter: register-file
// geometry, the buffered-write entry, and the output-register source select.
package wb_pkg;

  localparam int                    REG_ADDR_W = 5;
  localparam int                    REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [REG_DATA_W-1:0] wdata;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LD   = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_BYP  = 2'd3
  } wb_src_e;

  // x0 is hardwired: it never carries a pending write.
  function automatic logic addr_match(input logic [REG_ADDR_W-1:0] q,
                                      input logic [REG_ADDR_W-1:0] a);
    return (q != REG_ZERO) && (q == a);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer of pending ALU writes. Exposes per-slot valid bits and
// addresses so the top can match hazards against every buffered write.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  wb_entry_t                        push_data,
  output wb_entry_t                        head,
  output logic [CW-1:0]                    count,
  output logic [DEPTH-1:0]                 ent_vld,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr
);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic [CW-1:0]         count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: slots outside [rd, rd+count) are masked by ent_vld.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign head  = mem_q[rd_q];
  assign count = count_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    localparam logic [PW-1:0] IDX = PW'(i);
    logic [PW-1:0] off;
    assign off         = IDX - rd_q;
    assign ent_vld[i]  = {1'b0, off} < count_q;
    assign ent_addr[i] = mem_q[i].waddr;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges stallable ALU results and unstallable load returns onto the single
// register-file write port, buffering colliding ALU writes in order.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = REG_ADDR_W,
  parameter  int DW    = REG_DATA_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid_i,
  output logic          alu_ready_o,
  input  logic [AW-1:0] alu_waddr_i,
  input  logic [DW-1:0] alu_wdata_i,
  input  logic          ld_valid_i,
  input  logic [AW-1:0] ld_waddr_i,
  input  logic [DW-1:0] ld_wdata_i,
  output logic          reg_write_en,
  output logic [AW-1:0] reg_waddr_o,
  output logic [DW-1:0] reg_wdata_o,
  input  logic [AW-1:0] hz_raddr1_i,
  input  logic [AW-1:0] hz_raddr2_i,
  output logic          hz_hit1_o,
  output logic          hz_hit2_o,
  output logic [CW-1:0] fifo_count_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_entry_t                        fifo_head;
  wb_entry_t                        alu_ent;
  logic [CW-1:0]                    fifo_cnt;
  logic [DEPTH-1:0]                 ent_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;
  logic                             fifo_push, fifo_pop;
  logic                             alu_acc, alu_nz, ld_nz, fifo_empty;
  wb_src_e                          src;

  logic          out_we_q, out_we_d;
  logic [AW-1:0] out_waddr_q, out_waddr_d;
  logic [DW-1:0] out_wdata_q, out_wdata_d;

  // Ready depends only on the registered count, never on this cycle's load/pop.
  assign alu_ready_o = fifo_cnt < FULL_CNT;
  assign fifo_empty  = fifo_cnt == '0;
  assign alu_ent     = '{waddr: alu_waddr_i, wdata: alu_wdata_i};

  always_comb begin
    alu_acc   = alu_valid_i && alu_ready_o;
    alu_nz    = alu_acc && (alu_waddr_i != REG_ZERO);
    ld_nz     = ld_valid_i && (ld_waddr_i != REG_ZERO);
    src       = SRC_NONE;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (ld_nz) begin
      src       = SRC_LD;
      fifo_push = alu_nz;
    end else if (!fifo_empty) begin
      src       = SRC_FIFO;
      fifo_pop  = 1'b1;
      fifo_push = alu_nz;
    end else if (alu_nz) begin
      src       = SRC_BYP;
    end
  end

  always_comb begin
    out_we_d    = 1'b0;
    out_waddr_d = '0;
    out_wdata_d = '0;
    case (src)
      SRC_LD: begin
        out_we_d    = 1'b1;
        out_waddr_d = ld_waddr_i;
        out_wdata_d = ld_wdata_i;
      end
      SRC_FIFO: begin
        out_we_d    = 1'b1;
        out_waddr_d = fifo_head.waddr;
        out_wdata_d = fifo_head.wdata;
      end
      SRC_BYP: begin
        out_we_d    = 1'b1;
        out_waddr_d = alu_waddr_i;
        out_wdata_d = alu_wdata_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_we_q    <= 1'b0;
      out_waddr_q <= '0;
      out_wdata_q <= '0;
    end else begin
      out_we_q    <= out_we_d;
      out_waddr_q <= out_waddr_d;
      out_wdata_q <= out_wdata_d;
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .push_data(alu_ent),
    .head     (fifo_head),
    .count    (fifo_cnt),
    .ent_vld  (ent_vld),
    .ent_addr (ent_addr)
  );

  // A write in the output register is still pending until the end of this cycle.
  always_comb begin
    hz_hit1_o = out_we_q && addr_match(hz_raddr1_i, out_waddr_q);
    hz_hit2_o = out_we_q && addr_match(hz_raddr2_i, out_waddr_q);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && addr_match(hz_raddr1_i, ent_addr[i])) hz_hit1_o = 1'b1;
      if (ent_vld[i] && addr_match(hz_raddr2_i, ent_addr[i])) hz_hit2_o = 1'b1;
    end
  end

  assign reg_write_en = out_we_q;
  assign reg_waddr_o  = out_waddr_q;
  assign reg_wdata_o  = out_wdata_q;
  assign fifo_count_o = fifo_cnt;

endmodule
